apb_master: RTL and testbench

//  APB4 requester: converts a valid/ready command stream into APB SETUP/ACCESS transfers.

---
 rtl/apb_master.sv | 150 +++++++++++++++
 tb/tb_apb_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: APB4 requester. Turns a valid/ready command stream into single
// APB SETUP/ACCESS transfers and returns read data, slave error and timeout
// status on a valid/ready response channel. One transfer in flight at a time.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_ready only in IDLE
//   cmd_write/addr/wdata/strb  command fields, latched on accept
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/err/timeout    read data (0 for writes/timeouts), error, timeout flag
//   psel/penable/pwrite/paddr/pwdata/pstrb   APB request (all registered)
//   prdata/pready/pslverr    APB completion inputs
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready=1
// SETUP  | psel=1, penable=0, request fields stable
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// RESP   | rsp_valid=1 until rsp_ready
module apb_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             cmd_fire;
  logic             timeout_hit;
  logic             xfer_abort;

  // Gated with rst so nothing can look accepted while the block is held in reset.
  assign cmd_ready   = (state == IDLE) && !rst;
  assign cmd_fire    = cmd_valid && cmd_ready;

  // With TIMEOUT=0 the counter simply wraps and never aborts.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);
  // pready on the last allowed cycle takes priority over the abort.
  assign xfer_abort  = (state == ACCESS) && !pready && timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || xfer_abort) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            psel     <= 1'b1;
            pwrite   <= cmd_write;
            paddr    <= cmd_addr;
            pwdata   <= cmd_wdata;
            pstrb    <= cmd_write ? cmd_strb : '0;
            wait_cnt <= '0;
          end
        end
        SETUP: begin
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            pstrb       <= '0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            pstrb       <= '0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a hand-driven APB completer.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_chk  = 0;
  int n_pass = 0;
  int acc;

  apb_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command and lets it be accepted; returns in SETUP.
  task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  // From SETUP: completer answers on ACCESS cycle nwait+1. Returns ACCESS length.
  task automatic run_access(input int nwait, input logic [31:0] rd, input logic err,
                            output int acc_cycles);
    logic hit;
    logic done;
    acc_cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hit = 1'b0;
      if (penable) begin
        acc_cycles++;
        hit = (acc_cycles == nwait + 1);
      end
      pready  = hit;
      prdata  = hit ? rd : 32'hDEAD_BEEF;
      pslverr = hit ? err : 1'b0;
      step();
      if (rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    chk("rsp_within_budget", done, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_dropped", rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
    rsp_ready = 0; prdata = 0; pready = 0; pslverr = 0;
    step(); step();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", {rsp_err, rsp_timeout}, 0);
    rst = 1'b0;
    step();

    // 1: write, no wait states
    issue(1'b1, 12'h004, 32'hA5A5_0001, 4'hF);
    chk("t1_setup_psel", {psel, penable}, 2'b10);
    chk("t1_paddr", paddr, 12'h004);
    chk("t1_pwrite", pwrite, 1);
    chk("t1_pwdata", pwdata, 32'hA5A5_0001);
    chk("t1_pstrb", pstrb, 4'hF);
    pready = 1'b1; prdata = 32'hFFFF_FFFF;
    step();
    chk("t1_access", {psel, penable}, 2'b11);
    chk("t1_access_pstrb", pstrb, 4'hF);
    chk("t1_access_rsp_valid", rsp_valid, 0);
    step();
    pready = 1'b0;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_bus_idle", {psel, penable}, 2'b00);
    chk("t1_rsp_rdata", rsp_rdata, 0);
    chk("t1_rsp_err", {rsp_err, rsp_timeout}, 0);
    chk("t1_pstrb_cleared", pstrb, 0);
    chk("t1_paddr_held", paddr, 12'h004);
    take_rsp();
    chk("t1_cmd_ready_again", cmd_ready, 1);

    // 2: read with 3 wait states
    issue(1'b0, 12'h008, 32'h0, 4'hF);
    chk("t2_pstrb_read", pstrb, 0);
    chk("t2_pwrite", pwrite, 0);
    run_access(3, 32'h1234_5678, 1'b0, acc);
    chk("t2_access_len", acc, 4);
    chk("t2_rdata", rsp_rdata, 32'h1234_5678);
    chk("t2_err", {rsp_err, rsp_timeout}, 0);
    take_rsp();

    // 3: write with slave error
    issue(1'b1, 12'h00C, 32'h0000_00FF, 4'h3);
    chk("t3_pstrb", pstrb, 4'h3);
    run_access(0, 32'h5555_5555, 1'b1, acc);
    chk("t3_access_len", acc, 1);
    chk("t3_err", {rsp_err, rsp_timeout}, 2'b10);
    chk("t3_rdata_write", rsp_rdata, 0);
    take_rsp();

    // 4: timeout after 16 ACCESS cycles
    issue(1'b0, 12'h010, 32'h0, 4'h0);
    run_access(100, 32'h7777_7777, 1'b0, acc);
    chk("t4_access_len", acc, 16);
    chk("t4_err", {rsp_err, rsp_timeout}, 2'b11);
    chk("t4_rdata", rsp_rdata, 0);
    chk("t4_bus_idle", {psel, penable}, 2'b00);
    take_rsp();

    // 4b: pready on the abort cycle wins
    issue(1'b0, 12'h014, 32'h0, 4'h0);
    run_access(15, 32'h0F0F_1234, 1'b0, acc);
    chk("t4b_access_len", acc, 16);
    chk("t4b_err", {rsp_err, rsp_timeout}, 0);
    chk("t4b_rdata", rsp_rdata, 32'h0F0F_1234);
    take_rsp();

    // 5: response stall with next command waiting
    issue(1'b0, 12'h018, 32'h0, 4'h0);
    run_access(0, 32'hCAFE_F00D, 1'b0, acc);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020;
    cmd_wdata = 32'h1111_2222; cmd_strb = 4'hC;
    for (int i = 0; i < 5; i++) begin
      chk("t5_cmd_ready_stall", cmd_ready, 0);
      chk("t5_rsp_valid_held", rsp_valid, 1);
      chk("t5_rdata_stable", rsp_rdata, 32'hCAFE_F00D);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t5_rsp_done", rsp_valid, 0);
    chk("t5_cmd_ready_after", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("t5_next_setup", {psel, penable}, 2'b10);
    chk("t5_next_paddr", paddr, 12'h020);
    chk("t5_next_pstrb", pstrb, 4'hC);
    run_access(0, 32'h0, 1'b0, acc);
    chk("t5_next_rdata", rsp_rdata, 0);
    take_rsp();

    // 6: reset during ACCESS
    issue(1'b0, 12'h01C, 32'h0, 4'h0);
    step();
    chk("t6_in_access", {psel, penable}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_drop", {psel, penable}, 2'b00);
    step(); step();
    chk("t6_no_rsp", rsp_valid, 0);
    rst = 1'b0;
    step();
    chk("t6_no_rsp_after", rsp_valid, 0);
    issue(1'b0, 12'h024, 32'h0, 4'h0);
    run_access(1, 32'h0BAD_F00D, 1'b0, acc);
    chk("t6_access_len", acc, 2);
    chk("t6_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("t6_err", {rsp_err, rsp_timeout}, 0);
    take_rsp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
